camellia_decrypt_rounds: RTL and testbench

- Iterative, handshaked inverse of the team's 6-round Camellia Feistel group.
- Takes the 128-bit output of the encryption procedure (L, R) and six 64-bit subkeys, and runs the six rounds in reverse subkey order (K6 down to K1), one round per clock.
- Returns the original (L, R) pair.
- Uses a single shared F_function instance, treated as combinational (Z valid in the same cycle as X, K), instead of six unrolled copies.

---
 rtl/camellia_decrypt_rounds.sv | 173 +++++++++++++++++
 tb/tb_camellia_decrypt_rounds.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camellia_decrypt_rounds.sv
// Iterative inverse of the 6-round Camellia Feistel group: one round per clock,
// subkeys applied K6 down to K1 through a single shared F-function.

module camellia_f_function (
  input  logic [63:0] i_x,
  input  logic [63:0] i_k,
  output logic [63:0] o_z
);
  localparam int SBOX1 [256] = '{
    112, 130,  44, 236, 179,  39, 192, 229, 228, 133,  87,  53, 234,  12, 174,  65,
     35, 239, 107, 147,  69,  25, 165,  33, 237,  14,  79,  78,  29, 101, 146, 189,
    134, 184, 175, 143, 124, 235,  31, 206,  62,  48, 220,  95,  94, 197,  11,  26,
    166, 225,  57, 202, 213,  71,  93,  61, 217,   1,  90, 214,  81,  86, 108,  77,
    139,  13, 154, 102, 251, 204, 176,  45, 116,  18,  43,  32, 240, 177, 132, 153,
    223,  76, 203, 194,  52, 126, 118,   5, 109, 183, 169,  49, 209,  23,   4, 215,
     20,  88,  58,  97, 222,  27,  17,  28,  50,  15, 156,  22,  83,  24, 242,  34,
    254,  68, 207, 178, 195, 181, 122, 145,  36,   8, 232, 168,  96, 252, 105,  80,
    170, 208, 160, 125, 161, 137,  98, 151,  84,  91,  30, 149, 224, 255, 100, 210,
     16, 196,   0,  72, 163, 247, 117, 219, 138,   3, 230, 218,   9,  63, 221, 148,
    135,  92, 131,   2, 205,  74, 144,  51, 115, 103, 246, 243, 157, 127, 191, 226,
     82, 155, 216,  38, 200,  55, 198,  59, 129, 150, 111,  75,  19, 190,  99,  46,
    233, 121, 167, 140, 159, 110, 188, 142,  41, 245, 249, 182,  47, 253, 180,  89,
    120, 152,   6, 106, 231,  70, 113, 186, 212,  37, 171,  66, 136, 162, 141, 250,
    114,   7, 185,  85, 248, 238, 172,  10,  54,  73,  42, 104,  60,  56, 241, 164,
     64,  40, 211, 123, 187, 201,  67, 193,  21, 227, 173, 244, 119, 199, 128, 158
  };

  function automatic logic [7:0] s1(input logic [7:0] a);
    return 8'(SBOX1[a]);
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] a);
    return {a[6:0], a[7]};
  endfunction

  function automatic logic [7:0] rotr1(input logic [7:0] a);
    return {a[0], a[7:1]};
  endfunction

  logic [63:0] w_x;
  logic [7:0]  w_t [1:8];

  assign w_x = i_x ^ i_k;

  // s2 = rotl1(s1), s3 = rotr1(s1), s4 = s1(rotl1(x)); byte order t1..t8 is MSB first
  assign w_t[1] = s1(w_x[63:56]);
  assign w_t[2] = rotl1(s1(w_x[55:48]));
  assign w_t[3] = rotr1(s1(w_x[47:40]));
  assign w_t[4] = s1(rotl1(w_x[39:32]));
  assign w_t[5] = rotl1(s1(w_x[31:24]));
  assign w_t[6] = rotr1(s1(w_x[23:16]));
  assign w_t[7] = s1(rotl1(w_x[15:8]));
  assign w_t[8] = s1(w_x[7:0]);

  assign o_z[63:56] = w_t[1] ^ w_t[3] ^ w_t[4] ^ w_t[6] ^ w_t[7] ^ w_t[8];
  assign o_z[55:48] = w_t[1] ^ w_t[2] ^ w_t[4] ^ w_t[5] ^ w_t[7] ^ w_t[8];
  assign o_z[47:40] = w_t[1] ^ w_t[2] ^ w_t[3] ^ w_t[5] ^ w_t[6] ^ w_t[8];
  assign o_z[39:32] = w_t[2] ^ w_t[3] ^ w_t[4] ^ w_t[5] ^ w_t[6] ^ w_t[7];
  assign o_z[31:24] = w_t[1] ^ w_t[2] ^ w_t[6] ^ w_t[7] ^ w_t[8];
  assign o_z[23:16] = w_t[2] ^ w_t[3] ^ w_t[5] ^ w_t[7] ^ w_t[8];
  assign o_z[15:8]  = w_t[3] ^ w_t[4] ^ w_t[5] ^ w_t[6] ^ w_t[8];
  assign o_z[7:0]   = w_t[1] ^ w_t[4] ^ w_t[5] ^ w_t[6] ^ w_t[7];
endmodule

module camellia_decrypt_rounds (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [63:0] In_L,
  input  logic [63:0] In_R,
  input  logic [63:0] K1,
  input  logic [63:0] K2,
  input  logic [63:0] K3,
  input  logic [63:0] K4,
  input  logic [63:0] K5,
  input  logic [63:0] K6,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [63:0] OUT_L,
  output logic [63:0] OUT_R,
  output logic        BUSY
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_hi;
  logic [63:0] r_lo;
  logic [63:0] r_kr [1:6];
  logic [2:0]  r_cnt;
  logic        r_out_valid;
  logic [63:0] w_key;
  logic [63:0] w_f;
  logic        w_accept;

  assign IN_READY  = (r_state == S_IDLE) | ((r_state == S_DONE) & OUT_READY);
  assign w_accept  = IN_VALID & IN_READY;
  assign OUT_L     = r_hi;
  assign OUT_R     = r_lo;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = (r_state == S_ROUND);

  // Reverse key schedule: round cnt uses kr[6-cnt]
  always_comb begin
    w_key = '0;
    case (r_cnt)
      3'd0:    w_key = r_kr[6];
      3'd1:    w_key = r_kr[5];
      3'd2:    w_key = r_kr[4];
      3'd3:    w_key = r_kr[3];
      3'd4:    w_key = r_kr[2];
      3'd5:    w_key = r_kr[1];
      default: w_key = '0;
    endcase
  end

  camellia_f_function u_f (
    .i_x (r_lo),
    .i_k (w_key),
    .o_z (w_f)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 1; i <= 6; i++) r_kr[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_hi        <= In_L;
            r_lo        <= In_R;
            r_kr[1]     <= K1;
            r_kr[2]     <= K2;
            r_kr[3]     <= K3;
            r_kr[4]     <= K4;
            r_kr[5]     <= K5;
            r_kr[6]     <= K6;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= S_ROUND;
          end else if ((r_state == S_DONE) && OUT_READY) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_ROUND: begin
          if (r_cnt > 3'd5) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_hi <= r_lo;
            r_lo <= r_hi ^ w_f;
            if (r_cnt == 3'd5) begin
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_camellia_decrypt_rounds.sv
// Randomized round-trip bench: blocks are encrypted by a reference Feistel model
// here, decrypted by the DUT, and compared against the original plaintext.

module tb_camellia_decrypt_rounds;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        OUT_READY = 1'b0;
  logic        IN_READY, OUT_VALID, BUSY;
  logic [63:0] In_L = '0, In_R = '0;
  logic [63:0] K1 = '0, K2 = '0, K3 = '0, K4 = '0, K5 = '0, K6 = '0;
  logic [63:0] OUT_L, OUT_R;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  camellia_decrypt_rounds dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .In_L      (In_L),
    .In_R      (In_R),
    .K1        (K1),
    .K2        (K2),
    .K3        (K3),
    .K4        (K4),
    .K5        (K5),
    .K6        (K6),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_L     (OUT_L),
    .OUT_R     (OUT_R),
    .BUSY      (BUSY)
  );

  // Camellia SBOX1
  localparam int SB [256] = '{
    112, 130,  44, 236, 179,  39, 192, 229, 228, 133,  87,  53, 234,  12, 174,  65,
     35, 239, 107, 147,  69,  25, 165,  33, 237,  14,  79,  78,  29, 101, 146, 189,
    134, 184, 175, 143, 124, 235,  31, 206,  62,  48, 220,  95,  94, 197,  11,  26,
    166, 225,  57, 202, 213,  71,  93,  61, 217,   1,  90, 214,  81,  86, 108,  77,
    139,  13, 154, 102, 251, 204, 176,  45, 116,  18,  43,  32, 240, 177, 132, 153,
    223,  76, 203, 194,  52, 126, 118,   5, 109, 183, 169,  49, 209,  23,   4, 215,
     20,  88,  58,  97, 222,  27,  17,  28,  50,  15, 156,  22,  83,  24, 242,  34,
    254,  68, 207, 178, 195, 181, 122, 145,  36,   8, 232, 168,  96, 252, 105,  80,
    170, 208, 160, 125, 161, 137,  98, 151,  84,  91,  30, 149, 224, 255, 100, 210,
     16, 196,   0,  72, 163, 247, 117, 219, 138,   3, 230, 218,   9,  63, 221, 148,
    135,  92, 131,   2, 205,  74, 144,  51, 115, 103, 246, 243, 157, 127, 191, 226,
     82, 155, 216,  38, 200,  55, 198,  59, 129, 150, 111,  75,  19, 190,  99,  46,
    233, 121, 167, 140, 159, 110, 188, 142,  41, 245, 249, 182,  47, 253, 180,  89,
    120, 152,   6, 106, 231,  70, 113, 186, 212,  37, 171,  66, 136, 162, 141, 250,
    114,   7, 185,  85, 248, 238, 172,  10,  54,  73,  42, 104,  60,  56, 241, 164,
     64,  40, 211, 123, 187, 201,  67, 193,  21, 227, 173, 244, 119, 199, 128, 158
  };

  function automatic logic [7:0] sbox(input int which, input logic [7:0] a);
    logic [7:0] v;
    case (which)
      1:       v = 8'(SB[a]);
      2:       begin v = 8'(SB[a]); v = {v[6:0], v[7]}; end
      3:       begin v = 8'(SB[a]); v = {v[0], v[7:1]}; end
      default: v = 8'(SB[{a[6:0], a[7]}]);
    endcase
    return v;
  endfunction

  // F = P(S(x ^ k)); P expressed as one XOR-selection mask per output byte
  function automatic logic [63:0] ref_f(input logic [63:0] x, input logic [63:0] k);
    int         kind [8] = '{1, 2, 3, 4, 2, 3, 4, 1};
    logic [7:0] mask [8] = '{8'hB7, 8'hDB, 8'hED, 8'h7E, 8'hC7, 8'h6B, 8'h3D, 8'h9E};
    logic [7:0] t [8];
    logic [7:0] y;
    logic [63:0] v, z;
    v = x ^ k;
    z = '0;
    for (int j = 0; j < 8; j++) t[j] = sbox(kind[j], v[63-8*j -: 8]);
    for (int i = 0; i < 8; i++) begin
      y = '0;
      for (int j = 0; j < 8; j++) if (mask[i][7-j]) y ^= t[j];
      z[63-8*i -: 8] = y;
    end
    return z;
  endfunction

  // Encryption: per round L' = R ^ F(L, Ki), R' = L, keys K1..K6
  function automatic logic [127:0] ref_enc(input logic [127:0] p, input logic [5:0][63:0] k);
    logic [63:0] l, r, t;
    l = p[127:64];
    r = p[63:0];
    for (int i = 0; i < 6; i++) begin
      t = r ^ ref_f(l, k[i]);
      r = l;
      l = t;
    end
    return {l, r};
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] c, input logic [5:0][63:0] k);
    logic [63:0] l, r, t;
    l = c[127:64];
    r = c[63:0];
    for (int i = 5; i >= 0; i--) begin
      t = l ^ ref_f(r, k[i]);
      l = r;
      r = t;
    end
    return {l, r};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [5:0][63:0] rnd_keys();
    logic [5:0][63:0] k;
    for (int i = 0; i < 6; i++) k[i] = rnd64();
    return k;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [127:0] c, input logic [5:0][63:0] k);
    In_L = c[127:64];
    In_R = c[63:0];
    K1 = k[0]; K2 = k[1]; K3 = k[2]; K4 = k[3]; K5 = k[4]; K6 = k[5];
  endtask

  // Present a block and return just after the accepting edge
  task automatic send(input logic [127:0] c, input logic [5:0][63:0] k);
    int n;
    drive(c, k);
    IN_VALID = 1'b1;
    n = 0;
    while (!IN_READY && n < 20) begin step(); n++; end
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!OUT_VALID && lat < 40) begin step(); lat++; end
  endtask

  task automatic consume();
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    step();
    checks++;
    if (OUT_L !== 64'd0 || OUT_R !== 64'd0 || OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got L=%h R=%h V=%b B=%b, need all 0", OUT_L, OUT_R, OUT_VALID, BUSY);
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, need 1", IN_READY);
    end
    IN_VALID = 1'b1;
    step();
    step();
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: BUSY got %b, need 0", BUSY);
    end
    IN_VALID = 1'b0;
    RST = 1'b1;
    step();
    checks++;
    if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: BUSY=%b V=%b, need 0 0", BUSY, OUT_VALID);
    end
  endtask

  task automatic test_roundtrip();
    logic [127:0] pt, ct;
    logic [5:0][63:0] k;
    int lat;
    pt = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    for (int i = 0; i < 6; i++) k[i] = {16{4'(i + 1)}};
    ct = ref_enc(pt, k);
    send(ct, k);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL roundtrip_busy: got %b, need 1", BUSY);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL roundtrip_latency: got %0d cycles, need 6", lat);
    end
    checks++;
    if ({OUT_L, OUT_R} !== pt) begin
      errors++;
      $display("FAIL roundtrip_data: got %h_%h, need %h", OUT_L, OUT_R, pt);
    end
    $display("roundtrip: ct=%h out=%h_%h lat=%0d", ct, OUT_L, OUT_R, lat);
    consume();
    checks++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL roundtrip_consume: V=%b B=%b, need 0 0", OUT_VALID, BUSY);
    end
  endtask

  task automatic test_key_order();
    logic [127:0] pt, ct, exp;
    logic [5:0][63:0] k, ks;
    int lat;
    pt = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    for (int i = 0; i < 6; i++) k[i] = {16{4'(i + 1)}};
    ct = ref_enc(pt, k);
    ks = k;
    ks[0] = k[5];
    ks[5] = k[0];
    exp = ref_dec(ct, ks);
    send(ct, ks);
    wait_valid(lat);
    checks++;
    if ({OUT_L, OUT_R} !== exp) begin
      errors++;
      $display("FAIL key_order_data: got %h_%h, need %h", OUT_L, OUT_R, exp);
    end
    checks++;
    if ({OUT_L, OUT_R} === pt) begin
      errors++;
      $display("FAIL key_order_differs: got %h_%h, need anything but %h", OUT_L, OUT_R, pt);
    end
    $display("key_order: out=%h_%h", OUT_L, OUT_R);
    consume();
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, ct;
    logic [5:0][63:0] k;
    int lat, bad;
    pt = {rnd64(), rnd64()};
    k = rnd_keys();
    ct = ref_enc(pt, k);
    send(ct, k);
    wait_valid(lat);
    drive({rnd64(), rnd64()}, rnd_keys());
    IN_VALID = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (OUT_VALID !== 1'b1 || {OUT_L, OUT_R} !== pt || IN_READY !== 1'b0) begin
        errors++;
        bad++;
        $display("FAIL backpressure_hold[%0d]: V=%b out=%h_%h IN_READY=%b, need 1 %h 0",
                 c, OUT_VALID, OUT_L, OUT_R, IN_READY, pt);
      end
      step();
    end
    IN_VALID = 1'b0;
    consume();
    checks++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: V=%b B=%b, need 0 0", OUT_VALID, BUSY);
    end
    $display("backpressure: out=%h held 10 cycles, bad=%0d", pt, bad);
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt [8];
    logic [127:0] ct [8];
    logic [5:0][63:0] k [8];
    int lat;
    for (int i = 0; i < 8; i++) begin
      pt[i] = {rnd64(), rnd64()};
      k[i] = rnd_keys();
      ct[i] = ref_enc(pt[i], k[i]);
    end
    drive(ct[0], k[0]);
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i < 7) drive(ct[i+1], k[i+1]);
      else IN_VALID = 1'b0;
      wait_valid(lat);
      checks++;
      if (lat !== 6 || {OUT_L, OUT_R} !== pt[i]) begin
        errors++;
        $display("FAIL b2b_block[%0d]: got %h_%h after %0d cycles, need %h after 6",
                 i, OUT_L, OUT_R, lat, pt[i]);
      end
      $display("b2b[%0d]: out=%h_%h lat=%0d", i, OUT_L, OUT_R, lat);
      step();
      if (i < 7) begin
        checks++;
        if (BUSY !== 1'b1 || OUT_VALID !== 1'b0) begin
          errors++;
          $display("FAIL b2b_overlap[%0d]: B=%b V=%b, need 1 0", i, BUSY, OUT_VALID);
        end
      end
    end
    OUT_READY = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: B=%b V=%b, need 0 0", BUSY, OUT_VALID);
    end
  endtask

  task automatic test_ignored_input();
    logic [127:0] pt, ct;
    logic [5:0][63:0] k;
    int lat;
    pt = {rnd64(), rnd64()};
    k = rnd_keys();
    ct = ref_enc(pt, k);
    send(ct, k);
    step();
    step();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL ignored_busy: got %b, need 1", BUSY);
    end
    In_L = ~In_L;
    K3 = rnd64() ^ K3 ^ 64'h1;
    IN_VALID = 1'b1;
    wait_valid(lat);
    IN_VALID = 1'b0;
    checks++;
    if ({OUT_L, OUT_R} !== pt || lat !== 4) begin
      errors++;
      $display("FAIL ignored_data: got %h_%h after %0d more cycles, need %h after 4",
               OUT_L, OUT_R, lat, pt);
    end
    $display("ignored_input: out=%h_%h", OUT_L, OUT_R);
    consume();
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt, ct;
    logic [5:0][63:0] k;
    int lat, seen;
    pt = {rnd64(), rnd64()};
    k = rnd_keys();
    ct = ref_enc(pt, k);
    send(ct, k);
    step();
    step();
    step();
    RST = 1'b0;
    #1;
    checks++;
    if (OUT_L !== 64'd0 || OUT_R !== 64'd0 || OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: L=%h R=%h V=%b B=%b, need all 0", OUT_L, OUT_R, OUT_VALID, BUSY);
    end
    step();
    RST = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (OUT_VALID === 1'b1 || BUSY === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_discard: activity in %0d cycles, need 0", seen);
    end
    pt = {rnd64(), rnd64()};
    k = rnd_keys();
    ct = ref_enc(pt, k);
    send(ct, k);
    wait_valid(lat);
    checks++;
    if ({OUT_L, OUT_R} !== pt || lat !== 6) begin
      errors++;
      $display("FAIL midreset_fresh: got %h_%h after %0d, need %h after 6", OUT_L, OUT_R, lat, pt);
    end
    $display("reset_mid: fresh out=%h_%h lat=%0d", OUT_L, OUT_R, lat);
    consume();
  endtask

  initial begin
    test_reset();
    test_roundtrip();
    test_key_order();
    test_backpressure();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
